// File: rtl/muxq_deser_pkg.sv
// muxq_deser_pkg: shared types for the muxq deserializer slice.
// Holds the receive FSM state encoding and the bit-counter width.
package muxq_deser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   // Counter is sized for the largest legal word (32 bits), so it
   // covers 0..WIDTH for every WIDTH the deserializer accepts.
   localparam int MAX_WIDTH = 32;
   localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

endpackage

// File: rtl/muxq_out_buf.sv
// muxq_out_buf: output word register with valid/ready handshake and
// sticky overrun. Ports: clk_i, rst_ni, load_i (word complete strobe),
// data_i, ready_i, clr_i (clear overrun), word_o, valid_o, ovr_o.
module muxq_out_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o,
   output logic             ovr_o
);

   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             free;

   // Slot is free if empty or being drained this very cycle.
   assign free = !valid_q || ready_i;

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i && free) begin
         word_d  = data_i;
         valid_d = 1'b1;
      end
      // A new overrun event beats a simultaneous clear.
      ovr_d = (load_i && !free) || (ovr_q && !clr_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign word_o  = word_q;
   assign valid_o = valid_q;
   assign ovr_o   = ovr_q;

endmodule

// File: rtl/muxq_deserializer.sv
// muxq_deserializer: collects the mux flop Q bit stream into WIDTH-bit
// framed words. Inputs: Clock, Resetn, BitIn, BitValid, Start,
// WordReady, ClearErr. Outputs: Word, WordValid, Overrun, FrameErr,
// ParityErr. Define MUXQ_DESER_PARITY_EN for a trailing even-parity bit.
module muxq_deserializer
   import muxq_deser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             BitIn,
   input  logic             BitValid,
   input  logic             Start,
   input  logic             WordReady,
   input  logic             ClearErr,
   output logic [WIDTH-1:0] Word,
   output logic             WordValid,
   output logic             Overrun,
   output logic             FrameErr,
   output logic             ParityErr
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef MUXQ_DESER_PARITY_EN
   localparam bit     PAR_EN  = 1'b1;
   localparam state_e DONE_ST = PARITY;
`else
   localparam bit     PAR_EN  = 1'b0;
   localparam state_e DONE_ST = IDLE;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_q, frame_d;
   logic [WIDTH-1:0] sh_base, sh_nxt, bit_ext;
   logic [WIDTH-1:0] done_data;
   logic             done;
   logic             frame_ev;

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: Start always opens a new frame.
   always_comb begin
      state_d = state_q;
      if (BitValid) begin
         if (Start) begin
            state_d = (WIDTH == 1) ? DONE_ST : SHIFT;
         end else begin
            unique case (state_q)
               SHIFT:   if (cnt_q == LAST) state_d = DONE_ST;
               PARITY:  state_d = IDLE;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // A new frame shifts into a cleared register so no stale bits remain.
   always_comb begin
      sh_base = Start ? '0 : sh_q;
      bit_ext = WIDTH'(BitIn);
      if (MSB_FIRST != 0) begin
         sh_nxt = (sh_base << 1) | bit_ext;
      end else begin
         sh_nxt = (sh_base >> 1) | (bit_ext << (WIDTH - 1));
      end
   end

`ifdef MUXQ_DESER_PARITY_EN
   logic par_ev;
   logic par_q, par_d;
`endif

   // Output logic: completion strobe and error events.
   always_comb begin
      done      = 1'b0;
      frame_ev  = 1'b0;
      done_data = sh_nxt;
`ifdef MUXQ_DESER_PARITY_EN
      par_ev    = 1'b0;
`endif
      if (BitValid) begin
         if (Start) begin
            frame_ev = (state_q != IDLE);
            done     = (WIDTH == 1) && !PAR_EN;
         end else begin
            unique case (state_q)
               SHIFT: done = (cnt_q == LAST) && !PAR_EN;
`ifdef MUXQ_DESER_PARITY_EN
               PARITY: begin
                  if (BitIn == ^sh_q) begin
                     done      = 1'b1;
                     done_data = sh_q;
                  end else begin
                     par_ev = 1'b1;
                  end
               end
`endif
               default: done = 1'b0;
            endcase
         end
      end
   end

   // Shift register, bit counter and flag next-state.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (BitValid) begin
         if (Start) begin
            sh_d  = sh_nxt;
            cnt_d = CNT_W'(1);
         end else if (state_q == SHIFT) begin
            sh_d  = sh_nxt;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (state_d != SHIFT) begin
         cnt_d = '0;
      end
      frame_d = frame_ev || (frame_q && !ClearErr);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

`ifdef MUXQ_DESER_PARITY_EN
   assign par_d = par_ev || (par_q && !ClearErr);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign ParityErr = par_q;
`else
   assign ParityErr = 1'b0;
`endif

   assign FrameErr = frame_q;

   muxq_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk_i   (Clock),
      .rst_ni  (Resetn),
      .load_i  (done),
      .data_i  (done_data),
      .ready_i (WordReady),
      .clr_i   (ClearErr),
      .word_o  (Word),
      .valid_o (WordValid),
      .ovr_o   (Overrun)
   );

endmodule
